// File: rtl/cpu5_insn_encoder.sv
// Sequential RV32I instruction encoder: field-level requests in, 32-bit words tagged with word addresses out.
// Define CPU5_INSN_ENCODER_LI_EN to enable the LI pseudo-instruction (LUI+ADDI expansion).
module cpu5_insn_encoder #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_insn,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [3:0] K_R     = 4'd0;
  localparam logic [3:0] K_I     = 4'd1;
  localparam logic [3:0] K_LOAD  = 4'd2;
  localparam logic [3:0] K_STORE = 4'd3;
  localparam logic [3:0] K_BR    = 4'd4;
  localparam logic [3:0] K_JAL   = 4'd5;
  localparam logic [3:0] K_JALR  = 4'd6;
  localparam logic [3:0] K_LUI   = 4'd7;
  localparam logic [3:0] K_AUIPC = 4'd8;
`ifdef CPU5_INSN_ENCODER_LI_EN
  localparam logic [3:0] K_LI    = 4'd9;
`endif

  logic        in_idle;
  logic        accept;
  logic        legal;
  logic [31:0] word0;
  logic        out_fire;

  assign out_fire  = out_valid && out_ready;
  assign req_ready = !reset && in_idle && (!out_valid || out_ready);
  assign accept    = req_valid && req_ready;

`ifdef CPU5_INSN_ENCODER_LI_EN
  typedef enum logic {IDLE, LI2} state_t;

  state_t      state;
  state_t      state_next;
  logic        two_word;
  logic [31:0] word1;
  logic [31:0] pending;
  logic        li_fits;
  logic [31:0] li_round;

  assign in_idle  = (state == IDLE);
  assign li_fits  = (req_imm[31:11] == {21{req_imm[11]}});
  assign li_round = req_imm + 32'h0000_0800;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && legal && two_word) state_next = LI2;
      LI2:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
`else
  assign in_idle = 1'b1;
`endif

  // Field packing for the current request; legal=0 marks requests that only raise err.
  always_comb begin
    legal = 1'b1;
    word0 = '0;
`ifdef CPU5_INSN_ENCODER_LI_EN
    two_word = 1'b0;
    word1    = '0;
`endif
    case (req_kind)
      K_R:
        word0 = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, 7'h33};
      K_I:
        if (req_funct3 == 3'd1 || req_funct3 == 3'd5)
          word0 = {1'b0, (req_funct3 == 3'd5) & req_funct7b5, 5'b0, req_imm[4:0],
                   req_rs1, req_funct3, req_rd, 7'h13};
        else
          word0 = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'h13};
      K_LOAD: begin
        legal = !(req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
        word0 = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'h03};
      end
      K_STORE: begin
        legal = (req_funct3 < 3'd3);
        word0 = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], 7'h23};
      end
      K_BR: begin
        legal = !(req_funct3 == 3'd2 || req_funct3 == 3'd3) && !req_imm[0];
        word0 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                 req_imm[4:1], req_imm[11], 7'h63};
      end
      K_JAL: begin
        legal = !req_imm[0];
        word0 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'h6F};
      end
      K_JALR:
        word0 = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'h67};
      K_LUI:
        word0 = {req_imm[31:12], req_rd, 7'h37};
      K_AUIPC:
        word0 = {req_imm[31:12], req_rd, 7'h17};
`ifdef CPU5_INSN_ENCODER_LI_EN
      K_LI:
        if (li_fits) begin
          word0 = {req_imm[11:0], 5'd0, 3'b000, req_rd, 7'h13};
        end else begin
          // Rounding the upper part absorbs the sign extension of the ADDI immediate.
          two_word = 1'b1;
          word0    = {li_round[31:12], req_rd, 7'h37};
          word1    = {req_imm[11:0], req_rd, 3'b000, req_rd, 7'h13};
        end
`endif
      default:
        legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_insn  <= '0;
      out_addr  <= BASE_ADDR;
      err       <= 1'b0;
`ifdef CPU5_INSN_ENCODER_LI_EN
      pending   <= '0;
`endif
    end else begin
      if (out_fire) out_addr <= out_addr + ADDR_W'(1);
      if (accept && !legal) err <= 1'b1;
`ifdef CPU5_INSN_ENCODER_LI_EN
      if (accept && legal && two_word) pending <= word1;
      if (state == LI2) begin
        if (out_ready) out_insn <= pending;
      end else
`endif
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_insn  <= word0;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu5_insn_encoder.sv
// Self-checking bench for cpu5_insn_encoder: constant vector table, hand-written timing sequences,
// and randomized requests scored against an arithmetic RV32I encoding model.
module tb_cpu5_insn_encoder;

  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] BASE = '0;
`ifdef CPU5_INSN_ENCODER_LI_EN
  localparam bit LI_EN = 1'b1;
`else
  localparam bit LI_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_kind = '0;
  logic [2:0]        req_funct3 = '0;
  logic              req_funct7b5 = 1'b0;
  logic [4:0]        req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0]       req_imm = '0;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_insn;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  always #5 clk = ~clk;

  cpu5_insn_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr = BASE;
  logic              exp_err = 1'b0;

  bit   bp_mode = 1'b0;
  logic manual_ready = 1'b1;
  logic rand_ready = 1'b1;
  assign out_ready = bp_mode ? rand_ready : manual_ready;

  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    int          n;
    logic [31:0] w0, w1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] kind, input logic [2:0] f3, input logic f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input int n,
                              input logic [31:0] w0, input logic [31:0] w1);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.n = n; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  // Reference encoder: returns the number of words (0 = illegal) built by summing shifted fields.
  function automatic int ref_encode(input logic [3:0] kind, input logic [2:0] f3, input logic f7,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] imm,
                                    output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] r, s1, s2, f, hi;
    int s;
    r = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2); f = 32'(f3);
    s = $signed(imm);
    w0 = '0; w1 = '0;
    case (kind)
      4'd0: begin
        w0 = 32'h33 | r << 7 | f << 12 | s1 << 15 | s2 << 20 | (f7 ? 32'h4000_0000 : 32'h0);
        return 1;
      end
      4'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5)
          w0 = 32'h13 | r << 7 | f << 12 | s1 << 15 | fld(imm, 4, 0) << 20 |
               ((f3 == 3'd5 && f7) ? 32'h4000_0000 : 32'h0);
        else
          w0 = 32'h13 | r << 7 | f << 12 | s1 << 15 | fld(imm, 11, 0) << 20;
        return 1;
      end
      4'd2: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 0;
        w0 = 32'h03 | r << 7 | f << 12 | s1 << 15 | fld(imm, 11, 0) << 20;
        return 1;
      end
      4'd3: begin
        if (f3 >= 3'd3) return 0;
        w0 = 32'h23 | fld(imm, 4, 0) << 7 | f << 12 | s1 << 15 | s2 << 20 | fld(imm, 11, 5) << 25;
        return 1;
      end
      4'd4: begin
        if (f3 == 3'd2 || f3 == 3'd3 || imm[0]) return 0;
        w0 = 32'h63 | fld(imm, 11, 11) << 7 | fld(imm, 4, 1) << 8 | f << 12 | s1 << 15 |
             s2 << 20 | fld(imm, 10, 5) << 25 | fld(imm, 12, 12) << 31;
        return 1;
      end
      4'd5: begin
        if (imm[0]) return 0;
        w0 = 32'h6F | r << 7 | fld(imm, 19, 12) << 12 | fld(imm, 11, 11) << 20 |
             fld(imm, 10, 1) << 21 | fld(imm, 20, 20) << 31;
        return 1;
      end
      4'd6: begin
        w0 = 32'h67 | r << 7 | s1 << 15 | fld(imm, 11, 0) << 20;
        return 1;
      end
      4'd7: begin w0 = 32'h37 | r << 7 | (imm & 32'hFFFF_F000); return 1; end
      4'd8: begin w0 = 32'h17 | r << 7 | (imm & 32'hFFFF_F000); return 1; end
      4'd9: begin
        if (!LI_EN) return 0;
        if (s >= -2048 && s <= 2047) begin
          w0 = 32'h13 | r << 7 | fld(imm, 11, 0) << 20;
          return 1;
        end
        hi = (imm + 32'h800) >> 12;
        w0 = 32'h37 | r << 7 | hi << 12;
        w1 = 32'h13 | r << 7 | r << 15 | fld(imm, 11, 0) << 20;
        return 2;
      end
      default: return 0;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one request and wait for its handshake; expected words join the scoreboard on acceptance.
  task automatic apply_stimulus(input logic [3:0] kind, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input int n,
                                input logic [31:0] w0, input logic [31:0] w1, output int waited);
    bit accepted = 1'b0;
    req_kind = kind; req_funct3 = f3; req_funct7b5 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    waited = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        break;
      end
      waited++;
    end
    if (accepted) begin
      if (n == 0) exp_err = 1'b1;
      if (n >= 1) exp_q.push_back(w0);
      if (n >= 2) exp_q.push_back(w1);
      @(posedge clk);
      #1;
    end else begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL req_timeout: got req_ready=0 for 300 cycles, expected acceptance");
    end
    req_valid = 1'b0;
  endtask

  task automatic apply_random();
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, w0, w1;
    logic [31:0] edges[8];
    int n, waited;
    edges = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd0, 32'hFFFF_FFFF,
              32'h7FFF_F800, 32'h8000_0000};
    kind = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    f3 = 3'($urandom); f7 = 1'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 4))
      0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: imm = $urandom;
      2: imm = edges[$urandom_range(0, 7)];
      3: imm = $urandom & 32'hFFFF_FFFE;
      default: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
    endcase
    n = ref_encode(kind, f3, f7, rd, rs1, rs2, imm, w0, w1);
    apply_stimulus(kind, f3, f7, rd, rs1, rs2, imm, n, w0, w1, waited);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_addr = BASE;
    exp_err = 1'b0;
    #1;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_insn", out_insn, 32'd0);
    check_output("rst_out_addr", 32'(out_addr), 32'(BASE));
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Output scoreboard: every out handshake must match the oldest expected word and the running address.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL extra_word: got %h at addr %0d, expected no word", out_insn, out_addr);
        end else begin
          w = exp_q.pop_front();
          check_output("out_insn", out_insn, w);
          check_output("out_addr", 32'(out_addr), 32'(exp_addr));
        end
        exp_addr++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rand_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    logic [31:0] li_n1, li_n2, li_n3, li_n4;

    li_n1 = LI_EN ? 32'd2 : 32'd0;
    li_n2 = LI_EN ? 32'd2 : 32'd0;
    li_n3 = LI_EN ? 32'd1 : 32'd0;
    li_n4 = LI_EN ? 32'd1 : 32'd0;
    tbl.push_back(mk(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, 32'h0));
    tbl.push_back(mk(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3, 32'h0));
    tbl.push_back(mk(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1, 32'hFE208EE3, 32'h0));
    tbl.push_back(mk(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h3, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1, 1, 32'h00100293, 32'h0));
    tbl.push_back(mk(4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 1, 32'h40315093, 32'h0));
    tbl.push_back(mk(4'd1, 3'd1, 1'b1, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFE5, 1, 32'h00509093, 32'h0));
    tbl.push_back(mk(4'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0, 32'd8, 1, 32'h00812503, 32'h0));
    tbl.push_back(mk(4'd2, 3'd3, 1'b0, 5'd10, 5'd2, 5'd0, 32'd8, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd10, 32'd12, 1, 32'h00A12623, 32'h0));
    tbl.push_back(mk(4'd3, 3'd3, 1'b0, 5'd0, 5'd2, 5'd10, 32'd12, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1, 32'h008000EF, 32'h0));
    tbl.push_back(mk(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'd6, 3'd7, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 1, 32'h00008067, 32'h0));
    tbl.push_back(mk(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1, 32'h123452B7, 32'h0));
    tbl.push_back(mk(4'd8, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'hABCD_E123, 1, 32'hABCDE197, 32'h0));
    tbl.push_back(mk(4'd12, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0, 0, 32'h0, 32'h0));
    tbl.push_back(mk(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5678, int'(li_n1),
                     32'h123452B7, 32'h67828293));
    tbl.push_back(mk(4'd9, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'h800, int'(li_n2),
                     32'h00001337, 32'h80030313));
    tbl.push_back(mk(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, int'(li_n3),
                     32'hFFF00293, 32'h0));
    tbl.push_back(mk(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1, int'(li_n4), 32'h00100293, 32'h0));
    tbl.push_back(mk(4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1, 1, 32'h00100293, 32'h0));

    #2;
    do_reset();
    @(negedge clk);
    check_output("idle_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] vector table");
    manual_ready = 1'b1;
    foreach (tbl[i])
      apply_stimulus(tbl[i].kind, tbl[i].f3, tbl[i].f7, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                     tbl[i].imm, tbl[i].n, tbl[i].w0, tbl[i].w1, waited);
    drain();
    check_output("table_err", 32'(err), 32'(exp_err));
    check_output("table_idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] backpressure");
    do_reset();
    manual_ready = 1'b0;
    apply_stimulus(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, 32'h0, waited);
    req_kind = 4'd1; req_funct3 = 3'd0; req_rd = 5'd5; req_rs1 = 5'd0; req_imm = 32'd1;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("bp_req_ready", 32'(req_ready), 32'd0);
      check_output("bp_out_valid", 32'(out_valid), 32'd1);
      check_output("bp_out_insn", out_insn, 32'h002081B3);
      check_output("bp_out_addr", 32'(out_addr), 32'(BASE));
    end
    @(posedge clk);
    #1;
    manual_ready = 1'b1;
    apply_stimulus(4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1, 1, 32'h00100293, 32'h0, waited);
    check_output("bp_release_wait", 32'(waited), 32'd0);
    apply_stimulus(4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd10, 32'd12, 1, 32'h00A12623, 32'h0, waited);
    check_output("b2b_wait_1", 32'(waited), 32'd0);
    apply_stimulus(4'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0, 32'd8, 1, 32'h00812503, 32'h0, waited);
    check_output("b2b_wait_2", 32'(waited), 32'd0);
    drain();

    $display("[TB] LI ready gap");
    apply_stimulus(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5678, int'(li_n1),
                   32'h123452B7, 32'h67828293, waited);
    apply_stimulus(4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1, 1, 32'h00100293, 32'h0, waited);
    check_output("li_ready_gap", 32'(waited), LI_EN ? 32'd1 : 32'd0);
    drain();

    $display("[TB] reset during LI2");
    do_reset();
    manual_ready = 1'b0;
    apply_stimulus(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5678, int'(li_n1),
                   32'h123452B7, 32'h67828293, waited);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_addr = BASE;
    exp_err = 1'b0;
    #1;
    check_output("li2_rst_valid", 32'(out_valid), 32'd0);
    check_output("li2_rst_addr", 32'(out_addr), 32'(BASE));
    check_output("li2_rst_err", 32'(err), 32'd0);
    check_output("li2_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    manual_ready = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd1, 1, 32'h00100293, 32'h0, waited);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check_output("li2_after_valid", 32'(out_valid), 32'd0);
    check_output("li2_after_err", 32'(err), 32'd0);

    $display("[TB] randomized requests");
    do_reset();
    bp_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      apply_random();
    end
    bp_mode = 1'b0;
    manual_ready = 1'b1;
    drain();
    check_output("rand_err", 32'(err), 32'(exp_err));
    check_output("rand_final_addr", 32'(out_addr), 32'(exp_addr));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
